// File: rtl/fifo_pkg.sv
// Shared helpers for the flagged synchronous FIFO.
// Provides the count and pointer width calculations and the parameter
// legality check that the FIFO top evaluates at elaboration.
package fifo_pkg;

  // Occupancy runs from 0 to DEPTH inclusive, so it needs one more value than DEPTH.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width. $clog2 of very small depths can be 0, so the result is at least 1.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic bit params_legal(input int depth, input int af_thresh,
                                      input int ae_thresh);
    return (depth >= 2) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer incrementer with enable.
// ptr_i : current pointer (0..DEPTH-1)
// en_i  : advance the pointer
// ptr_o : next pointer. It wraps from DEPTH-1 to 0 for any DEPTH,
//         including depths that are not a power of two.
module fifo_ptr_wrap #(
  parameter int DEPTH = 2,
  parameter int PW    = 1
) (
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  always_comb begin
    ptr_o = ptr_i;
    if (en_i) begin
      if (ptr_i == PW'(DEPTH - 1)) ptr_o = '0;
      else                         ptr_o = ptr_i + PW'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO. It has an occupancy count,
// programmable almost-full and almost-empty flags, and sticky error flags.
// clk, arst_n       : rising-edge clock, asynchronous active-low reset
// wEn, wData        : write request and data
// rEn               : pop the head entry
// rData             : head entry (combinational, don't-care while empty)
// clr_err           : synchronous clear of overflow and underflow
// empty, full, almost_empty, almost_full, count : registered status
// overflow, underflow : sticky flags for a rejected write or read
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          wEn,
  input  logic [DATA_WIDTH-1:0]         wData,
  input  logic                          rEn,
  output logic [DATA_WIDTH-1:0]         rData,
  input  logic                          clr_err,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  if (!params_legal(DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
    $error("sync_fifo_flags: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q, aempty_q, afull_q, ovf_q, udf_q;
  logic          wr_ok, rd_ok;

  // A write into a full FIFO is accepted when a pop frees a slot on the same edge.
  assign wr_ok = wEn & (~full_q | rEn);
  assign rd_ok = rEn & ~empty_q;

  assign count_d = count_q + CW'(wr_ok) - CW'(rd_ok);

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_wptr (
    .ptr_i (wptr_q),
    .en_i  (wr_ok),
    .ptr_o (wptr_d)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PW(PW)) u_rptr (
    .ptr_i (rptr_q),
    .en_i  (rd_ok),
    .ptr_o (rptr_d)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= wData;
  end

  // Status is decoded from the next count so every flag is a plain register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CW'(DEPTH));
      aempty_q <= (count_d <= CW'(AE_THRESH));
      afull_q  <= (count_d >= CW'(AF_THRESH));
      // A new error in the same cycle as clr_err takes priority over the clear.
      if (wEn && !wr_ok)  ovf_q <= 1'b1;
      else if (clr_err)   ovf_q <= 1'b0;
      if (rEn && !rd_ok)  udf_q <= 1'b1;
      else if (clr_err)   udf_q <= 1'b0;
    end
  end

  assign rData        = mem[rptr_q];
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DEPTH 5, AF 4, AE 1, 8-bit data).
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          wEn, rEn, clr_err;
  logic [DW-1:0] wData, rData;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;
  logic [CW-1:0] count;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .wEn          (wEn),
    .wData        (wData),
    .rEn          (rEn),
    .rData        (rData),
    .clr_err      (clr_err),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Scoreboard: accepted write data is pushed and popped as reads occur.
  logic [DW-1:0] sb[$];
  logic          m_ovf, m_udf;

  typedef struct {
    logic          w;
    logic [DW-1:0] wd;
    logic          r;
    logic          clr;
    int            cnt;
    logic          e, f, ae, af, ov, un;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(sb.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
    chk({tag, ".ae"},    32'(almost_empty), 32'(sb.size() <= AE));
    chk({tag, ".af"},    32'(almost_full),  32'(sb.size() >= AF));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, ".udf"},   32'(underflow), 32'(m_udf));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".empty"}, 32'(empty), 32'd1);
    chk({tag, ".full"},  32'(full),  32'd0);
    chk({tag, ".ae"},    32'(almost_empty), 32'd1);
    chk({tag, ".af"},    32'(almost_full),  32'd0);
    chk({tag, ".ovf"},   32'(overflow),  32'd0);
    chk({tag, ".udf"},   32'(underflow), 32'd0);
  endtask

  // One clock cycle. Inputs are driven at the negedge. Head data is compared
  // before the edge and status after it.
  task automatic cycle(input logic w, input logic [DW-1:0] wd, input logic r, input logic c,
                       input string tag);
    logic          wr, rd;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    wEn = w; wData = wd; rEn = r; clr_err = c;
    rd = r && (sb.size() != 0);
    wr = w && ((sb.size() < DEPTH) || r);
    #1;
    if (rd) begin
      exp_d = sb.pop_front();
      chk({tag, ".rdata"}, 32'(rData), 32'(exp_d));
    end
    if (wr) sb.push_back(wd);
    if (w && !wr) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && !rd) m_udf = 1'b1; else if (c) m_udf = 1'b0;
    @(posedge clk);
    #1;
    wEn = 1'b0; rEn = 1'b0; clr_err = 1'b0;
    chk_model(tag);
  endtask

  initial begin
    // Fill-to-full, overflow, then drain and clear.
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1'b1, 8'h12, 1'b0, 1'b0, 2, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 8'h13, 1'b0, 1'b0, 3, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 8'h14, 1'b0, 1'b0, 4, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{1'b1, 8'h15, 1'b0, 1'b0, 5, 0, 1, 0, 1, 0, 0};
    tbl[5]  = '{1'b1, 8'h99, 1'b0, 1'b0, 5, 0, 1, 0, 1, 1, 0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4, 0, 0, 0, 1, 1, 0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 0, 0, 1, 0, 1, 0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1, 0, 1, 0, 1, 0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1, 0, 1, 0, 0, 0};

    wEn = 1'b0; rEn = 1'b0; clr_err = 1'b0; wData = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk_reset_vals("reset");

    // Tests 1-2: table-driven vectors, with the scoreboard checking read order.
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].w, tbl[i].wd, tbl[i].r, tbl[i].clr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tcount", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d.tflags", i),
          {26'd0, empty, full, almost_empty, almost_full, overflow, underflow},
          {26'd0, tbl[i].e, tbl[i].f, tbl[i].ae, tbl[i].af, tbl[i].ov, tbl[i].un});
    end

    // Test 3: simultaneous write/read while full, across pointer wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, "fill");
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, "wr_rd_full");
      chk("wr_rd_full.cnt5", 32'(count), 32'd5);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");

    // Test 4: underflow, clear, and an error that coincides with a clear.
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "udf_set");
    chk("udf_set.direct", 32'(underflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "udf_clr");
    chk("udf_clr.direct", 32'(underflow), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, "udf_clr_race");
    chk("udf_clr_race.direct", 32'(underflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "udf_clr2");

    // Test 5: write and read together on an empty FIFO.
    cycle(1'b1, 8'hAB, 1'b1, 1'b0, "empty_wr_rd");
    chk("empty_wr_rd.cnt", 32'(count), 32'd1);
    chk("empty_wr_rd.udf", 32'(underflow), 32'd1);
    chk("empty_wr_rd.rdata", 32'(rData), 32'hAB);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, "pop_ab");

    // Test 6: asynchronous reset with data stored, then a round trip.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, "pre_rst");
    chk("pre_rst.cnt", 32'(count), 32'd3);
    @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    sb.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, "rt_wr");
    chk("rt_wr.rdata", 32'(rData), 32'h5A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "rt_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
